acc_seq_ctrl: RTL and testbench



---
 rtl/acc_seq_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_acc_seq_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_seq_ctrl.sv
// Instruction sequencer for the 8-bit dual-accumulator datapath: owns A/B and carries CA/CB,
// fetches memory operands, drives the external ALU, writes results back and resolves branches.
module acc_seq_ctrl #(
  parameter int unsigned MEM_AW = 8
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iInstValid,
  output logic              oInstReady,
  input  logic [5:0]        iOpcode,
  input  logic [7:0]        iOperand,
  output logic [7:0]        oAluOper1,
  output logic [7:0]        oAluOper2,
  output logic [5:0]        oAluInstSel,
  input  logic [7:0]        iAluData,
  input  logic              iAluBCA,
  input  logic              iAluBCB,
  output logic [MEM_AW-1:0] oMemAddr,
  output logic              oMemRd,
  output logic              oMemWr,
  output logic [7:0]        oMemWrData,
  input  logic [7:0]        iMemRdData,
  input  logic              iMemAck,
  output logic [7:0]        oAccA,
  output logic [7:0]        oAccB,
  output logic              oCA,
  output logic              oCB,
  output logic              oBranchTaken,
  output logic [7:0]        oBranchTarget,
  output logic              oIllegal,
  output logic              oDone
);

  localparam logic [5:0] OpLdb   = 6'h01;
  localparam logic [5:0] OpLdcb  = 6'h03;
  localparam logic [5:0] OpSta   = 6'h04;
  localparam logic [5:0] OpStb   = 6'h05;
  localparam logic [5:0] OpAdda  = 6'h06;
  localparam logic [5:0] OpSuba  = 6'h0A;
  localparam logic [5:0] OpSubcb = 6'h0D;
  localparam logic [5:0] OpOrcb  = 6'h15;
  localparam logic [5:0] OpAsla  = 6'h16;
  localparam logic [5:0] OpAsra  = 6'h17;
  localparam logic [5:0] OpJmp   = 6'h18;
  localparam logic [5:0] OpBapl  = 6'h1E;
  localparam logic [5:0] OpBbeq  = 6'h1F;
  localparam logic [5:0] OpBbpl  = 6'h24;

  typedef enum logic [2:0] {
    StIdle,
    StMemRd,
    StExec,
    StMemWr,
    StDone
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------------------------------
  function automatic logic op_illegal(input logic [5:0] op);
    return op > OpBbpl;
  endfunction

  function automatic logic op_load(input logic [5:0] op);
    return op <= OpLdb;
  endfunction

  function automatic logic op_ldc(input logic [5:0] op);
    return (op > OpLdb) && (op <= OpLdcb);
  endfunction

  function automatic logic op_store(input logic [5:0] op);
    return (op == OpSta) || (op == OpStb);
  endfunction

  function automatic logic op_alu(input logic [5:0] op);
    return (op >= OpAdda) && (op <= OpOrcb);
  endfunction

  // ALU ops come in groups of four: X-A, X-B, X-CA, X-CB; bit 1 of the offset marks the C form.
  function automatic logic op_alu_c(input logic [5:0] op);
    logic [5:0] idx;
    idx = op - OpAdda;
    return op_alu(op) && idx[1];
  endfunction

  function automatic logic op_shift(input logic [5:0] op);
    return (op == OpAsla) || (op == OpAsra);
  endfunction

  function automatic logic op_b_target(input logic [5:0] op);
    return (op <= OpOrcb) && op[0];
  endfunction

  function automatic logic op_sub(input logic [5:0] op);
    return (op >= OpSuba) && (op <= OpSubcb);
  endfunction

  function automatic logic op_carry(input logic [5:0] op);
    return (op >= OpAdda) && (op <= OpSubcb);
  endfunction

  // Returns {oper1, oper2}. The ALU computes oper2 - oper1, so B subtractions swap the operands.
  function automatic logic [15:0] alu_route(input logic [5:0] op, input logic [7:0] m,
                                            input logic [7:0] a, input logic [7:0] b);
    if (op_shift(op)) begin
      return {a, 8'h00};
    end
    if (op_b_target(op)) begin
      return op_sub(op) ? {m, b} : {b, m};
    end
    return {a, m};
  endfunction

  // Conditions per accumulator in order EQ, NE, CS, CC, MI, PL.
  function automatic logic branch_eval(input logic [5:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic ca, input logic cb);
    logic [7:0] acc;
    logic       c;
    logic [5:0] idx;
    if (op == OpJmp) begin
      return 1'b1;
    end
    if (op <= OpBapl) begin
      acc = a;
      c   = ca;
      idx = op - (OpJmp + 6'd1);
    end else begin
      acc = b;
      c   = cb;
      idx = op - OpBbeq;
    end
    case (idx)
      6'd0:    return acc == 8'h00;
      6'd1:    return acc != 8'h00;
      6'd2:    return c;
      6'd3:    return !c;
      6'd4:    return acc[7];
      default: return !acc[7];
    endcase
  endfunction

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [5:0]          op_q, op_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                taken_q, taken_d;
  logic                illegal_q, illegal_d;
  logic [7:0]          target_q, target_d;
  logic [7:0]          acc_a_q, acc_a_d;
  logic [7:0]          acc_b_q, acc_b_d;
  logic                ca_q, ca_d;
  logic                cb_q, cb_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          oper1_q, oper1_d;
  logic [7:0]          oper2_q, oper2_d;
  logic [5:0]          sel_q, sel_d;
  logic [15:0]         route;
  logic                xfer;

  assign xfer = iInstValid && ready_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    target_d  = target_q;
    acc_a_d   = acc_a_q;
    acc_b_d   = acc_b_q;
    ca_d      = ca_q;
    cb_d      = cb_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    oper1_d   = 8'h00;
    oper2_d   = 8'h00;
    sel_d     = 6'h00;
    route     = 16'h0000;

    case (state_q)
      StIdle: begin
        if (xfer) begin
          op_d     = iOpcode;
          target_d = iOperand;
          addr_d   = MEM_AW'(iOperand);
          if (op_illegal(iOpcode)) begin
            illegal_d = 1'b1;
            state_d   = StDone;
          end else if (op_load(iOpcode) || (op_alu(iOpcode) && !op_alu_c(iOpcode))) begin
            rd_d    = 1'b1;
            state_d = StMemRd;
          end else if (op_store(iOpcode)) begin
            wr_d    = 1'b1;
            wdata_d = iOpcode[0] ? acc_b_q : acc_a_q;
            state_d = StMemWr;
          end else if (op_ldc(iOpcode)) begin
            if (iOpcode[0]) acc_b_d = iOperand;
            else            acc_a_d = iOperand;
            state_d = StDone;
          end else if (op_alu_c(iOpcode) || op_shift(iOpcode)) begin
            route              = alu_route(iOpcode, iOperand, acc_a_q, acc_b_q);
            {oper1_d, oper2_d} = route;
            sel_d              = iOpcode;
            state_d            = StExec;
          end else begin
            taken_d = branch_eval(iOpcode, acc_a_q, acc_b_q, ca_q, cb_q);
            state_d = StDone;
          end
        end
      end
      StMemRd: begin
        if (iMemAck) begin
          rd_d = 1'b0;
          if (op_load(op_q)) begin
            if (op_q[0]) acc_b_d = iMemRdData;
            else         acc_a_d = iMemRdData;
            state_d = StDone;
          end else begin
            route              = alu_route(op_q, iMemRdData, acc_a_q, acc_b_q);
            {oper1_d, oper2_d} = route;
            sel_d              = op_q;
            state_d            = StExec;
          end
        end
      end
      StExec: begin
        if (op_b_target(op_q)) begin
          acc_b_d = iAluData;
          if (op_carry(op_q)) cb_d = iAluBCB;
        end else begin
          acc_a_d = iAluData;
          if (op_carry(op_q)) ca_d = iAluBCA;
        end
        state_d = StDone;
      end
      StMemWr: begin
        if (iMemAck) begin
          wr_d    = 1'b0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    done_d  = (state_d == StDone);
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q   <= StIdle;
      op_q      <= 6'h00;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      target_q  <= 8'h00;
      acc_a_q   <= 8'h00;
      acc_b_q   <= 8'h00;
      ca_q      <= 1'b0;
      cb_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      oper1_q   <= 8'h00;
      oper2_q   <= 8'h00;
      sel_q     <= 6'h00;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
      target_q  <= target_d;
      acc_a_q   <= acc_a_d;
      acc_b_q   <= acc_b_d;
      ca_q      <= ca_d;
      cb_q      <= cb_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      oper1_q   <= oper1_d;
      oper2_q   <= oper2_d;
      sel_q     <= sel_d;
    end
  end

  assign oInstReady    = ready_q;
  assign oAluOper1     = oper1_q;
  assign oAluOper2     = oper2_q;
  assign oAluInstSel   = sel_q;
  assign oMemAddr      = addr_q;
  assign oMemRd        = rd_q;
  assign oMemWr        = wr_q;
  assign oMemWrData    = wdata_q;
  assign oAccA         = acc_a_q;
  assign oAccB         = acc_b_q;
  assign oCA           = ca_q;
  assign oCB           = cb_q;
  assign oBranchTaken  = taken_q;
  assign oBranchTarget = target_q;
  assign oIllegal      = illegal_q;
  assign oDone         = done_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Randomized bench for acc_seq_ctrl: plays the ALU and data memory, and predicts each
// instruction's effect, latency and branch outcome from the instruction set semantics.
module tb_acc_seq_ctrl;

  logic       iClk;
  logic       iReset;
  logic       iInstValid;
  logic       oInstReady;
  logic [5:0] iOpcode;
  logic [7:0] iOperand;
  logic [7:0] oAluOper1;
  logic [7:0] oAluOper2;
  logic [5:0] oAluInstSel;
  logic [7:0] iAluData;
  logic       iAluBCA;
  logic       iAluBCB;
  logic [7:0] oMemAddr;
  logic       oMemRd;
  logic       oMemWr;
  logic [7:0] oMemWrData;
  logic [7:0] iMemRdData;
  logic       iMemAck;
  logic [7:0] oAccA;
  logic [7:0] oAccB;
  logic       oCA;
  logic       oCB;
  logic       oBranchTaken;
  logic [7:0] oBranchTarget;
  logic       oIllegal;
  logic       oDone;

  acc_seq_ctrl #(.MEM_AW(8)) u_dut (
    .iClk          (iClk),
    .iReset        (iReset),
    .iInstValid    (iInstValid),
    .oInstReady    (oInstReady),
    .iOpcode       (iOpcode),
    .iOperand      (iOperand),
    .oAluOper1     (oAluOper1),
    .oAluOper2     (oAluOper2),
    .oAluInstSel   (oAluInstSel),
    .iAluData      (iAluData),
    .iAluBCA       (iAluBCA),
    .iAluBCB       (iAluBCB),
    .oMemAddr      (oMemAddr),
    .oMemRd        (oMemRd),
    .oMemWr        (oMemWr),
    .oMemWrData    (oMemWrData),
    .iMemRdData    (iMemRdData),
    .iMemAck       (iMemAck),
    .oAccA         (oAccA),
    .oAccB         (oAccB),
    .oCA           (oCA),
    .oCB           (oCB),
    .oBranchTaken  (oBranchTaken),
    .oBranchTarget (oBranchTarget),
    .oIllegal      (oIllegal),
    .oDone         (oDone)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Behavioural ALU: carry of the non-target side is random so a swapped carry pick shows up.
  logic [8:0] alu_r9;
  logic       alu_b_op;
  logic       noise;
  always @(posedge iClk) noise <= 1'($urandom);
  always_comb begin
    alu_r9 = 9'h000;
    if (oAluInstSel >= 6'h06 && oAluInstSel <= 6'h09)
      alu_r9 = {1'b0, oAluOper1} + {1'b0, oAluOper2};
    else if (oAluInstSel >= 6'h0A && oAluInstSel <= 6'h0D)
      alu_r9 = {1'b0, oAluOper2} - {1'b0, oAluOper1};
    else if (oAluInstSel >= 6'h0E && oAluInstSel <= 6'h11)
      alu_r9 = {1'b0, oAluOper1 & oAluOper2};
    else if (oAluInstSel >= 6'h12 && oAluInstSel <= 6'h15)
      alu_r9 = {1'b0, oAluOper1 | oAluOper2};
    else if (oAluInstSel == 6'h16)
      alu_r9 = {oAluOper1[7], oAluOper1[6:0], 1'b0};
    else if (oAluInstSel == 6'h17)
      alu_r9 = {oAluOper1[0], oAluOper1[7], oAluOper1[7:1]};
  end
  assign alu_b_op = (oAluInstSel <= 6'h15) && oAluInstSel[0];
  assign iAluData = alu_r9[7:0];
  assign iAluBCA  = alu_b_op ? noise : alu_r9[8];
  assign iAluBCB  = alu_b_op ? alu_r9[8] : noise;

  int n_vec;
  int n_miss;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference state
  logic [7:0] m_a, m_b;
  logic       m_ca, m_cb;
  logic [7:0] mem [256];

  task automatic run_inst(input logic [5:0] op, input logic [7:0] opnd, input int k,
                          input bit hold);
    logic [7:0] m, val, acc, e1, e2, ea, eb;
    logic [8:0] r9;
    logic       eca, ecb, etk, eil, c, ealu, done, alu_seen;
    int         idx, g, lat, n, rd_n, wr_n;
    bit         bsel, csel;
    ea = m_a; eb = m_b; eca = m_ca; ecb = m_cb;
    etk = 1'b0; eil = 1'b0; ealu = 1'b0; e1 = 8'h00; e2 = 8'h00; lat = 1;
    m = mem[opnd];
    r9 = 9'h000;
    if (op > 6'h24) begin
      eil = 1'b1;
    end else if (op >= 6'h18) begin
      if (op == 6'h18) begin
        etk = 1'b1;
      end else begin
        idx = (op <= 6'h1E) ? int'(op) - 25 : int'(op) - 31;
        acc = (op <= 6'h1E) ? m_a : m_b;
        c   = (op <= 6'h1E) ? m_ca : m_cb;
        case (idx)
          0:       etk = (acc == 8'h00);
          1:       etk = (acc != 8'h00);
          2:       etk = c;
          3:       etk = !c;
          4:       etk = acc[7];
          default: etk = !acc[7];
        endcase
      end
    end else if (op >= 6'h16) begin
      lat = 2; ealu = 1'b1; e1 = m_a; e2 = 8'h00;
      ea = (op == 6'h16) ? {m_a[6:0], 1'b0} : {m_a[7], m_a[7:1]};
    end else if (op >= 6'h06) begin
      idx  = int'(op) - 6;
      g    = idx / 4;
      bsel = (idx % 2) == 1;
      csel = ((idx / 2) % 2) == 1;
      val  = csel ? opnd : m;
      acc  = bsel ? m_b : m_a;
      lat  = csel ? 2 : 2 + k;
      ealu = 1'b1;
      case (g)
        0:       r9 = {1'b0, acc} + {1'b0, val};
        1:       r9 = bsel ? ({1'b0, acc} - {1'b0, val}) : ({1'b0, val} - {1'b0, acc});
        2:       r9 = {1'b0, acc & val};
        default: r9 = {1'b0, acc | val};
      endcase
      if (bsel && g == 1) begin e1 = val; e2 = m_b; end
      else begin e1 = acc; e2 = val; end
      if (bsel) begin
        eb = r9[7:0];
        if (g < 2) ecb = r9[8];
      end else begin
        ea = r9[7:0];
        if (g < 2) eca = r9[8];
      end
    end else if (op <= 6'h01) begin
      lat = 1 + k;
      if (op[0]) eb = m; else ea = m;
    end else if (op <= 6'h03) begin
      if (op[0]) eb = opnd; else ea = opnd;
    end else begin
      lat = 1 + k;
    end

    check_val("ready_before", 32'(oInstReady), 32'd1);
    iInstValid = 1'b1; iOpcode = op; iOperand = opnd;
    @(negedge iClk);
    if (!hold) iInstValid = 1'b0;
    n = 1; rd_n = 0; wr_n = 0; done = 1'b0; alu_seen = 1'b0;
    while (!done && n <= 24) begin
      if (oMemRd) begin
        rd_n++;
        if (rd_n == k) begin
          check_val("rd_addr", 32'(oMemAddr), 32'(opnd));
          iMemRdData = mem[oMemAddr];
          iMemAck = 1'b1;
        end
      end
      if (oMemWr) begin
        wr_n++;
        check_val("wr_data", 32'(oMemWrData), 32'(op[0] ? m_b : m_a));
        if (wr_n == k) begin
          check_val("wr_addr", 32'(oMemAddr), 32'(opnd));
          iMemAck = 1'b1;
        end
      end
      if (oAluInstSel != 6'h00 && !alu_seen) begin
        alu_seen = 1'b1;
        check_val("alu_sel", 32'(oAluInstSel), 32'(op));
        check_val("alu_oper1", 32'(oAluOper1), 32'(e1));
        check_val("alu_oper2", 32'(oAluOper2), 32'(e2));
      end
      if (oDone) begin
        done = 1'b1;
        check_val("latency", 32'(n), 32'(lat));
        check_val("taken", 32'(oBranchTaken), 32'(etk));
        check_val("target", 32'(oBranchTarget), 32'(opnd));
        check_val("illegal", 32'(oIllegal), 32'(eil));
        check_val("acc_a", 32'(oAccA), 32'(ea));
        check_val("acc_b", 32'(oAccB), 32'(eb));
        check_val("carries", 32'({oCA, oCB}), 32'({eca, ecb}));
      end else begin
        check_val("busy_ready", 32'(oInstReady), 32'd0);
        @(negedge iClk);
        iMemAck = 1'b0;
        iMemRdData = 8'($urandom);
        n++;
      end
    end
    iInstValid = 1'b0;
    check_val("done_seen", 32'(done), 32'd1);
    check_val("alu_used", 32'(alu_seen), 32'(ealu));
    m_a = ea; m_b = eb; m_ca = eca; m_cb = ecb;
    if (op == 6'h04 || op == 6'h05) mem[opnd] = op[0] ? m_b : m_a;
    @(negedge iClk);
    check_val("done_pulse", 32'({oDone, oBranchTaken, oIllegal}), 32'd0);
    check_val("ready_after", 32'(oInstReady), 32'd1);
  endtask

  initial begin
    logic [5:0] op;
    logic [7:0] opnd;
    n_vec = 0; n_miss = 0;
    iReset = 1'b1; iInstValid = 1'b0; iOpcode = 6'h00; iOperand = 8'h00;
    iMemRdData = 8'h00; iMemAck = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_ca = 1'b0; m_cb = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    @(negedge iClk);
    @(negedge iClk);
    check_val("rst_acc", 32'({oAccA, oAccB}), 32'd0);
    check_val("rst_ctrl", 32'({oInstReady, oCA, oCB, oMemRd, oMemWr, oDone, oBranchTaken,
                              oIllegal}), 32'd0);
    check_val("rst_alu", 32'({oAluOper1, oAluOper2, oAluInstSel}), 32'd0);
    iReset = 1'b0;
    @(negedge iClk);
    check_val("ready_post_rst", 32'(oInstReady), 32'd1);

    // Make state non-zero, then reset in the middle of a read that never acks
    run_inst(6'h02, 8'h55, 1, 1'b0);
    run_inst(6'h03, 8'h66, 1, 1'b0);
    run_inst(6'h08, 8'hF0, 1, 1'b0);
    iInstValid = 1'b1; iOpcode = 6'h00; iOperand = 8'h20;
    @(negedge iClk);
    iInstValid = 1'b0;
    check_val("mid_rd", 32'(oMemRd), 32'd1);
    #2 iReset = 1'b1;
    #1;
    check_val("rst_async_rd", 32'(oMemRd), 32'd0);
    check_val("rst_async_acc", 32'({oAccA, oAccB, oCA, oCB, oDone}), 32'd0);
    @(negedge iClk);
    iReset = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_ca = 1'b0; m_cb = 1'b0;
    @(negedge iClk);
    check_val("rst_recover", 32'({oInstReady, oDone}), 32'b10);

    run_inst(6'h02, 8'hF0, 1, 1'b0);
    run_inst(6'h08, 8'h20, 1, 1'b0);
    check_val("addca_a", 32'({oAccA, oCA, oCB}), 32'({8'h10, 1'b1, 1'b0}));

    run_inst(6'h03, 8'h05, 1, 1'b0);
    run_inst(6'h02, 8'h03, 1, 1'b0);
    run_inst(6'h0D, 8'h03, 1, 1'b0);
    check_val("subcb_b", 32'(oAccB), 32'h02);

    run_inst(6'h02, 8'h01, 1, 1'b0);
    mem[8'h40] = 8'h7F;
    run_inst(6'h06, 8'h40, 3, 1'b0);
    check_val("adda_a", 32'(oAccA), 32'h80);
    run_inst(6'h1D, 8'h11, 1, 1'b0);
    run_inst(6'h1E, 8'h12, 1, 1'b0);

    run_inst(6'h02, 8'h00, 1, 1'b0);
    run_inst(6'h19, 8'h33, 1, 1'b0);
    run_inst(6'h1A, 8'h33, 1, 1'b0);
    run_inst(6'h3F, 8'h77, 1, 1'b0);

    run_inst(6'h03, 8'hAA, 1, 1'b0);
    run_inst(6'h05, 8'h10, 3, 1'b1);
    run_inst(6'h01, 8'h10, 2, 1'b0);
    check_val("stb_ldb", 32'(oAccB), 32'hAA);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(6'h25, 6'h3F));
      else                           op = 6'($urandom_range(0, 6'h24));
      opnd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_inst(op, opnd, int'($urandom_range(1, 4)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
